// File: rtl/pid_controller_core_if.sv
// -----------------------------------------------------------------------------
// pid_controller_core_if
// Sample, parameter and result bundle for one PID lock-loop channel.
//   master : drives the sample stream, parameter set, update and lock controls;
//            receives the PID result and post-processed output word
//   slave  : the PID core
// Signals:
//   data_in/dv_in          signed input sample and its one-cycle valid
//   setpoint_in            signed setpoint
//   p/i/d_coef_in          signed PID coefficients
//   init_in/min_in/max_in  output offset and clamp bounds (unsigned)
//   update_in              one-cycle strobe latching all parameter inputs
//   lock_en_in             1 = loop closed, 0 = loop open
//   pid_data_out/dv_out    saturated signed PID result and its valid
//   opp_data_out/dv_out    offset+clamped output word and its valid
// -----------------------------------------------------------------------------
interface pid_controller_core_if #(
  parameter int W_DATA = 18,
  parameter int W_COEF = 16,
  parameter int W_OUT  = 16
);
  logic signed [W_DATA-1:0] data_in;
  logic                     dv_in;
  logic signed [W_COEF-1:0] setpoint_in;
  logic signed [W_COEF-1:0] p_coef_in;
  logic signed [W_COEF-1:0] i_coef_in;
  logic signed [W_COEF-1:0] d_coef_in;
  logic        [W_OUT-1:0]  init_in;
  logic        [W_OUT-1:0]  min_in;
  logic        [W_OUT-1:0]  max_in;
  logic                     update_in;
  logic                     lock_en_in;
  logic signed [W_DATA-1:0] pid_data_out;
  logic                     pid_dv_out;
  logic        [W_OUT-1:0]  opp_data_out;
  logic                     opp_dv_out;

  modport master (
    output data_in, dv_in, setpoint_in, p_coef_in, i_coef_in, d_coef_in,
    output init_in, min_in, max_in, update_in, lock_en_in,
    input  pid_data_out, pid_dv_out, opp_data_out, opp_dv_out
  );

  modport slave (
    input  data_in, dv_in, setpoint_in, p_coef_in, i_coef_in, d_coef_in,
    input  init_in, min_in, max_in, update_in, lock_en_in,
    output pid_data_out, pid_dv_out, opp_data_out, opp_dv_out
  );
endinterface

// File: rtl/pid_controller_core.sv
// -----------------------------------------------------------------------------
// pid_controller_core
// Single-channel PID filter for the lock loop followed by output offset and
// clamp. Per accepted sample: u = P*e + I*sum(e) + D*(e - e_prev), with
// e = setpoint - data; u is saturated to W_DATA bits, then init is added and
// the result clamped to [min, max] (max wins if min > max).
// Ports:
//   clk_in  system clock, rising edge
//   rst_in  synchronous active-high reset
//   bus     pid_controller_core_if slave: samples, parameters, results
// Latency: sample cycle T -> pid_dv_out at T+3, opp_dv_out at T+4,
// one sample per cycle throughput.
// -----------------------------------------------------------------------------
module pid_controller_core #(
  parameter int W_DATA = 18,
  parameter int W_COEF = 16,
  parameter int W_OUT  = 16,
  parameter int W_INT  = 32
) (
  input logic                 clk_in,
  input logic                 rst_in,
  pid_controller_core_if.slave bus
);

  localparam int W_E    = W_DATA + 1;      // error
  localparam int W_D    = W_DATA + 2;      // derivative
  localparam int W_INT1 = W_INT + 1;
  localparam int W_PP   = W_COEF + W_E;
  localparam int W_PI   = W_COEF + W_INT;
  localparam int W_PD   = W_COEF + W_D;
  localparam int W_SUM  = W_PI + 2;        // assumes W_INT >= W_DATA + 2
  localparam int W_V    = W_OUT + W_DATA;
  localparam int W_OUT1 = W_OUT + 1;

  function automatic logic signed [W_INT-1:0] sat_int(
    input logic signed [W_INT-1:0] acc,
    input logic signed [W_E-1:0]   e
  );
    logic signed [W_INT:0] s;
    s = W_INT1'(acc) + W_INT1'(e);
    if (s[W_INT] != s[W_INT-1])
      sat_int = s[W_INT] ? {1'b1, {(W_INT-1){1'b0}}} : {1'b0, {(W_INT-1){1'b1}}};
    else
      sat_int = s[W_INT-1:0];
  endfunction

  function automatic logic signed [W_DATA-1:0] sat_data(
    input logic signed [W_SUM-1:0] x
  );
    // In range when every bit above the result sign bit equals it.
    if ((&x[W_SUM-1:W_DATA-1]) || !(|x[W_SUM-1:W_DATA-1]))
      sat_data = x[W_DATA-1:0];
    else if (x[W_SUM-1])
      sat_data = {1'b1, {(W_DATA-1){1'b0}}};
    else
      sat_data = {1'b0, {(W_DATA-1){1'b1}}};
  endfunction

  function automatic logic [W_OUT-1:0] clamp_out(
    input logic        [W_OUT-1:0]  init,
    input logic        [W_OUT-1:0]  lo,
    input logic        [W_OUT-1:0]  hi,
    input logic signed [W_DATA-1:0] pid
  );
    logic signed [W_V-1:0] v;
    logic signed [W_V-1:0] vlo;
    logic signed [W_V-1:0] vhi;
    v   = W_V'(signed'(W_OUT1'(init))) + W_V'(pid);
    vlo = W_V'(signed'(W_OUT1'(lo)));
    vhi = W_V'(signed'(W_OUT1'(hi)));
    // Upper bound applied last so it wins when lo > hi.
    if (v < vlo) v = vlo;
    if (v > vhi) v = vhi;
    clamp_out = v[W_OUT-1:0];
  endfunction

  // Latched parameter set
  logic signed [W_COEF-1:0] r_setpoint, r_p_coef, r_i_coef, r_d_coef;
  logic        [W_OUT-1:0]  r_init, r_min, r_max;

  // Loop state
  logic signed [W_INT-1:0]  r_integral;
  logic signed [W_E-1:0]    r_err_prev;
  logic                     r_lock_d;

  // Pipeline
  logic                     r_vld_p1, r_vld_p2;
  logic signed [W_E-1:0]    r_e_p1;
  logic signed [W_COEF-1:0] r_pc_p1, r_ic_p1, r_dc_p1;
  logic signed [W_PP-1:0]   r_prod_p_p2;
  logic signed [W_PI-1:0]   r_prod_i_p2;
  logic signed [W_PD-1:0]   r_prod_d_p2;
  logic signed [W_DATA-1:0] r_pid_data;
  logic                     r_pid_dv;
  logic        [W_OUT-1:0]  r_opp_data;
  logic                     r_opp_dv;

  logic                     w_accept;
  logic                     w_lock_fall;
  logic signed [W_INT-1:0]  w_int_next;
  logic signed [W_D-1:0]    w_deriv;
  logic signed [W_PP-1:0]   w_prod_p;
  logic signed [W_PI-1:0]   w_prod_i;
  logic signed [W_PD-1:0]   w_prod_d;
  logic signed [W_SUM-1:0]  w_sum;

  assign w_accept    = bus.dv_in & bus.lock_en_in;
  assign w_lock_fall = r_lock_d & ~bus.lock_en_in;

  assign w_int_next = sat_int(r_integral, r_e_p1);
  assign w_deriv    = W_D'(r_e_p1) - W_D'(r_err_prev);
  assign w_prod_p   = W_PP'(r_e_p1) * W_PP'(r_pc_p1);
  assign w_prod_i   = W_PI'(w_int_next) * W_PI'(r_ic_p1);
  assign w_prod_d   = W_PD'(w_deriv) * W_PD'(r_dc_p1);
  assign w_sum      = W_SUM'(r_prod_p_p2) + W_SUM'(r_prod_i_p2) + W_SUM'(r_prod_d_p2);

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_setpoint  <= '0;
      r_p_coef    <= '0;
      r_i_coef    <= '0;
      r_d_coef    <= '0;
      r_init      <= '0;
      r_min       <= '0;
      r_max       <= '0;
      r_integral  <= '0;
      r_err_prev  <= '0;
      r_lock_d    <= 1'b0;
      r_vld_p1    <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_e_p1      <= '0;
      r_pc_p1     <= '0;
      r_ic_p1     <= '0;
      r_dc_p1     <= '0;
      r_prod_p_p2 <= '0;
      r_prod_i_p2 <= '0;
      r_prod_d_p2 <= '0;
      r_pid_data  <= '0;
      r_pid_dv    <= 1'b0;
      r_opp_data  <= '0;
      r_opp_dv    <= 1'b0;
    end else begin
      r_lock_d <= bus.lock_en_in;
      if (bus.update_in) begin
        r_setpoint <= bus.setpoint_in;
        r_p_coef   <= bus.p_coef_in;
        r_i_coef   <= bus.i_coef_in;
        r_d_coef   <= bus.d_coef_in;
        r_init     <= bus.init_in;
        r_min      <= bus.min_in;
        r_max      <= bus.max_in;
      end

      // p1: error; coefficients travel with the sample so a later update
      // cannot change a sample already in flight
      r_vld_p1 <= w_accept;
      if (w_accept) begin
        r_e_p1  <= W_E'(r_setpoint) - W_E'(bus.data_in);
        r_pc_p1 <= r_p_coef;
        r_ic_p1 <= r_i_coef;
        r_dc_p1 <= r_d_coef;
      end

      // p2: loop state update and products; opening the loop clears history
      r_vld_p2 <= r_vld_p1 & bus.lock_en_in;
      if (!bus.lock_en_in) begin
        r_integral <= '0;
        r_err_prev <= '0;
      end else if (r_vld_p1) begin
        r_integral  <= w_int_next;
        r_err_prev  <= r_e_p1;
        r_prod_p_p2 <= w_prod_p;
        r_prod_i_p2 <= w_prod_i;
        r_prod_d_p2 <= w_prod_d;
      end

      // p3: sum and saturate
      r_pid_dv <= r_vld_p2 & bus.lock_en_in;
      if (r_vld_p2 && bus.lock_en_in)
        r_pid_data <= sat_data(w_sum);

      // p4: offset and clamp; on unlock the output parks at clamped init
      r_opp_dv <= r_pid_dv & bus.lock_en_in;
      if (w_lock_fall)
        r_opp_data <= clamp_out(r_init, r_min, r_max, '0);
      else if (r_pid_dv && bus.lock_en_in)
        r_opp_data <= clamp_out(r_init, r_min, r_max, r_pid_data);
    end
  end

  assign bus.pid_data_out = r_pid_data;
  assign bus.pid_dv_out   = r_pid_dv;
  assign bus.opp_data_out = r_opp_data;
  assign bus.opp_dv_out   = r_opp_dv;

endmodule

// File: tb/tb_pid_controller_core.sv
// -----------------------------------------------------------------------------
// tb_pid_controller_core
// Directed bench for pid_controller_core: reset state, open-loop rejection,
// PID arithmetic and saturation, offset/clamp, update/sample collision,
// unlock mid-stream and reset mid-stream.
// -----------------------------------------------------------------------------
module tb_pid_controller_core;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;
  int   dv_cnt;

  always #5 clk = ~clk;

  pid_controller_core_if #(.W_DATA(18), .W_COEF(16), .W_OUT(16)) bus ();

  pid_controller_core #(.W_DATA(18), .W_COEF(16), .W_OUT(16), .W_INT(32)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_params(input int sp, input int p, input int i, input int d,
                            input int init, input int lo, input int hi);
    @(posedge clk); #1;
    bus.setpoint_in = 16'(sp);
    bus.p_coef_in   = 16'(p);
    bus.i_coef_in   = 16'(i);
    bus.d_coef_in   = 16'(d);
    bus.init_in     = 16'(init);
    bus.min_in      = 16'(lo);
    bus.max_in      = 16'(hi);
    bus.update_in   = 1'b1;
    @(posedge clk); #1;
    bus.update_in   = 1'b0;
  endtask

  // One isolated sample; checks result latency (T+3 / T+4) and values.
  task automatic run_sample(input string tag, input int data, input int exp_pid, input int exp_opp);
    @(posedge clk); #1;
    bus.data_in = 18'(data);
    bus.dv_in   = 1'b1;
    @(posedge clk); #1;
    bus.dv_in   = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check({tag, " pid_dv"}, int'(bus.pid_dv_out), 1);
    check({tag, " pid"}, int'(bus.pid_data_out), exp_pid);
    @(posedge clk); #1;
    check({tag, " opp_dv"}, int'(bus.opp_dv_out), 1);
    check({tag, " opp"}, int'(bus.opp_data_out), exp_opp);
    check({tag, " pid_dv one-shot"}, int'(bus.pid_dv_out), 0);
  endtask

  task automatic count_dv(input int cycles, output int cnt);
    cnt = 0;
    for (int k = 0; k < cycles; k++) begin
      @(posedge clk); #1;
      cnt += int'(bus.pid_dv_out) + int'(bus.opp_dv_out);
    end
  endtask

  initial begin
    bus.data_in = '0; bus.dv_in = 1'b0; bus.setpoint_in = '0;
    bus.p_coef_in = '0; bus.i_coef_in = '0; bus.d_coef_in = '0;
    bus.init_in = '0; bus.min_in = '0; bus.max_in = '0;
    bus.update_in = 1'b0; bus.lock_en_in = 1'b0;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("reset pid", int'(bus.pid_data_out), 0);
    check("reset pid_dv", int'(bus.pid_dv_out), 0);
    check("reset opp", int'(bus.opp_data_out), 0);
    check("reset opp_dv", int'(bus.opp_dv_out), 0);

    // Open loop: sample ignored
    @(posedge clk); #1;
    bus.data_in = 18'(100); bus.dv_in = 1'b1;
    @(posedge clk); #1;
    bus.dv_in = 1'b0;
    count_dv(6, dv_cnt);
    check("open-loop dv count", dv_cnt, 0);

    // PID arithmetic and integral growth into saturation
    set_params(0, 10, 3, 2, 0, 0, 0);
    bus.lock_en_in = 1'b1;
    run_sample("s1", 6000, -90000, 0);
    run_sample("s2", 6000, -96000, 0);
    run_sample("s3", 6000, -114000, 0);
    run_sample("s4 sat", 6000, -131072, 0);
    run_sample("s5 sat", 6000, -131072, 0);

    // Back-to-back samples: one result per cycle
    @(posedge clk); #1;
    bus.data_in = 18'(6000); bus.dv_in = 1'b1;
    @(posedge clk); #1;
    bus.data_in = 18'(6000);
    @(posedge clk); #1;
    bus.dv_in = 1'b0;
    @(posedge clk); #1;
    check("burst0 pid_dv", int'(bus.pid_dv_out), 1);
    check("burst0 pid", int'(bus.pid_data_out), -131072);
    @(posedge clk); #1;
    check("burst1 pid_dv", int'(bus.pid_dv_out), 1);
    check("burst1 pid", int'(bus.pid_data_out), -131072);
    @(posedge clk); #1;
    check("burst end pid_dv", int'(bus.pid_dv_out), 0);

    // Reopen loop: history cleared, first sample uses deriv = e
    @(posedge clk); #1 bus.lock_en_in = 1'b0;
    repeat (2) @(posedge clk);
    #1 bus.lock_en_in = 1'b1;
    run_sample("fresh", 10, -150, 0);

    // Offset and clamp
    set_params(0, 1, 0, 0, 5000, 1111, 9999);
    run_sample("opp mid", -3000, 3000, 8000);
    run_sample("opp hi", -6000, 6000, 9999);
    run_sample("opp lo", 4000, -4000, 1111);

    // Update in the same cycle as a sample: sample sees old P
    @(posedge clk); #1;
    bus.p_coef_in = 16'(2); bus.update_in = 1'b1;
    bus.data_in = 18'(-1000); bus.dv_in = 1'b1;
    @(posedge clk); #1;
    bus.update_in = 1'b0; bus.dv_in = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    check("collide pid", int'(bus.pid_data_out), 1000);
    @(posedge clk); #1;
    check("collide opp", int'(bus.opp_data_out), 6000);
    run_sample("newP", -1000, 2000, 7000);

    // min > max: max wins
    set_params(0, 1, 0, 0, 5000, 9000, 100);
    run_sample("min>max", -1000, 1000, 100);

    // Drop lock with a sample in flight
    set_params(0, 1, 0, 0, 5000, 1111, 9999);
    @(posedge clk); #1;
    bus.data_in = 18'(-1000); bus.dv_in = 1'b1;
    @(posedge clk); #1;
    bus.dv_in = 1'b0; bus.lock_en_in = 1'b0;
    count_dv(6, dv_cnt);
    check("unlock dv count", dv_cnt, 0);
    check("unlock opp", int'(bus.opp_data_out), 5000);

    // Re-lock with cleared history
    bus.lock_en_in = 1'b1;
    set_params(0, 10, 3, 2, 5000, 1111, 9999);
    run_sample("relock", 10, -150, 4850);

    // Reset with a sample in flight
    @(posedge clk); #1;
    bus.data_in = 18'(-1000); bus.dv_in = 1'b1;
    @(posedge clk); #1;
    bus.dv_in = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst pid", int'(bus.pid_data_out), 0);
    check("midrst opp", int'(bus.opp_data_out), 0);
    count_dv(6, dv_cnt);
    check("midrst dv count", dv_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
